// File: rtl/dmem_pkg.sv
// Shared types, funct3 codes, MMIO register offsets and access-size helpers
// for the data-memory subsystem.
package dmem_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_DONE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_MMIO = 2'd2
    } ld_src_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] GPIO_OFS      = 4'h0;
    localparam logic [3:0] CYCLE_LO_OFS  = 4'h4;
    localparam logic [3:0] CYCLE_HI_OFS  = 4'h8;
    localparam logic [3:0] STORE_CNT_OFS = 4'hC;

    // Codes outside the five legal ones behave as a word access.
    function automatic acc_size_t access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: access_size = SZ_BYTE;
            F3_H, F3_HU: access_size = SZ_HALF;
            default:     access_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] ofs);
        case (access_size(funct3))
            SZ_BYTE: lane_mask = 4'b0001 << ofs;
            SZ_HALF: lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] ofs);
        case (access_size(funct3))
            SZ_HALF: misaligned = ofs[0];
            SZ_WORD: misaligned = |ofs;
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage request/response bundle between the core and the data-memory subsystem.
interface dmem_if;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        misaligned_o;

    modport master (
        output req_i, we_i, funct3_i, addr_i, wdata_i,
        input  rdata_o, stall_o, misaligned_o
    );

    modport slave (
        input  req_i, we_i, funct3_i, addr_i, wdata_i,
        output rdata_o, stall_o, misaligned_o
    );
endinterface

// File: rtl/dmem_mmio_regs.sv
// MMIO register window: GPIO, free-running 64-bit cycle counter with a
// coherent high-word shadow, and a committed-store counter.
module dmem_mmio_regs
    import dmem_pkg::*;
#(
    parameter int unsigned GPIO_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rd_en,
    input  logic [1:0]        rd_word,
    input  logic              gpio_we,
    input  logic [GPIO_W-1:0] gpio_wdata,
    input  logic              ram_store,
    output logic [31:0]       rd_data,
    output logic [GPIO_W-1:0] gpio_o
);

    logic [GPIO_W-1:0] gpio_q;
    logic [63:0]       cycle_q;
    logic [31:0]       hi_shadow_q;
    logic [31:0]       store_cnt_q;
    logic [31:0]       rd_data_q;

    // Reading CYCLE_LO captures the high word on the same edge so LO/HI pairs stay coherent.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gpio_q      <= '0;
            cycle_q     <= '0;
            hi_shadow_q <= '0;
            store_cnt_q <= '0;
            rd_data_q   <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (gpio_we) begin
                gpio_q <= gpio_wdata;
            end
            if (ram_store) begin
                store_cnt_q <= store_cnt_q + 32'd1;
            end
            if (rd_en) begin
                case ({rd_word, 2'b00})
                    GPIO_OFS:      rd_data_q <= 32'(gpio_q);
                    CYCLE_LO_OFS: begin
                        rd_data_q   <= cycle_q[31:0];
                        hi_shadow_q <= cycle_q[63:32];
                    end
                    CYCLE_HI_OFS:  rd_data_q <= hi_shadow_q;
                    STORE_CNT_OFS: rd_data_q <= store_cnt_q;
                    default:       rd_data_q <= '0;
                endcase
            end
        end
    end

    assign rd_data = rd_data_q;
    assign gpio_o  = gpio_q;

endmodule

// File: rtl/dmem_subsystem.sv
// MEM-stage data memory: sync-read byte-lane RAM, two-cycle load handshake,
// alignment checks, load extension and the MMIO register window.
module dmem_subsystem
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0001_0000,
    parameter int unsigned GPIO_W      = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    dmem_if.slave             bus,
    output logic [GPIO_W-1:0] gpio_o
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned RAM_BYTES = 4 * DEPTH_WORDS;

    state_t           state_q;
    state_t           state_d;
    ld_src_t          ld_src_d;
    ld_src_t          ld_src_q;
    logic [2:0]       ld_f3_q;
    logic [1:0]       ld_ofs_q;

    logic [IDX_W-1:0] idx;
    logic             in_ram;
    logic             in_mmio;
    logic             mis;
    logic             accept_ld;
    logic             accept_st;
    logic             ram_we;
    logic             gpio_we;
    logic             mmio_rd;
    logic [3:0]       lanes;
    logic [31:0]      wdata_rep;
    logic [31:0]      ram_q;
    logic [31:0]      mmio_rd_data;
    logic [31:0]      raw;
    logic [31:0]      ext;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    logic [31:0]      ram [DEPTH_WORDS];

    assign idx     = bus.addr_i[IDX_W+1:2];
    assign in_ram  = bus.addr_i < 32'(RAM_BYTES);
    assign in_mmio = bus.addr_i[31:4] == MMIO_BASE[31:4];
    assign mis     = misaligned(bus.funct3_i, bus.addr_i[1:0]);
    assign lanes   = lane_mask(bus.funct3_i, bus.addr_i[1:0]);

    assign accept_ld = (state_q == IDLE) && bus.req_i && !bus.we_i;
    assign accept_st = (state_q == IDLE) && bus.req_i && bus.we_i && !mis && !reset_i;
    assign ram_we    = accept_st && in_ram;
    assign gpio_we   = accept_st && !in_ram && in_mmio
                       && (access_size(bus.funct3_i) == SZ_WORD)
                       && (bus.addr_i[3:2] == GPIO_OFS[3:2]);
    assign mmio_rd   = accept_ld && !mis && !in_ram && in_mmio;

    // Replicate store data across lanes so the byte-enable mask alone picks the target.
    always_comb begin
        wdata_rep = bus.wdata_i;
        case (access_size(bus.funct3_i))
            SZ_BYTE: wdata_rep = {4{bus.wdata_i[7:0]}};
            SZ_HALF: wdata_rep = {2{bus.wdata_i[15:0]}};
            default: wdata_rep = bus.wdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && lanes[b]) begin
                ram[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
        if (accept_ld) begin
            ram_q <= ram[idx];
        end
    end

    always_comb begin
        ld_src_d = SRC_ZERO;
        if (!mis) begin
            if (in_ram) begin
                ld_src_d = SRC_RAM;
            end else if (in_mmio) begin
                ld_src_d = SRC_MMIO;
            end
        end
    end

    // Load context held across the accept edge for extension in LOAD_DONE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ld_src_q <= SRC_ZERO;
            ld_f3_q  <= F3_W;
            ld_ofs_q <= '0;
        end else if (accept_ld) begin
            ld_src_q <= ld_src_d;
            ld_f3_q  <= bus.funct3_i;
            ld_ofs_q <= bus.addr_i[1:0];
        end
    end

    dmem_mmio_regs #(
        .GPIO_W (GPIO_W)
    ) u_regs (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rd_en      (mmio_rd),
        .rd_word    (bus.addr_i[3:2]),
        .gpio_we    (gpio_we),
        .gpio_wdata (bus.wdata_i[GPIO_W-1:0]),
        .ram_store  (ram_we),
        .rd_data    (mmio_rd_data),
        .gpio_o     (gpio_o)
    );

    always_comb begin
        case (ld_src_q)
            SRC_RAM:  raw = ram_q;
            SRC_MMIO: raw = mmio_rd_data;
            default:  raw = '0;
        endcase
        byte_sel = raw[{ld_ofs_q, 3'b000} +: 8];
        half_sel = raw[{ld_ofs_q[1], 4'b0000} +: 16];
        case (ld_f3_q)
            F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext = {24'h0, byte_sel};
            F3_H:    ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext = {16'h0, half_sel};
            default: ext = raw;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.req_i && !bus.we_i) state_d = LOAD_DONE;
            LOAD_DONE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.stall_o      = 1'b0;
        bus.misaligned_o = 1'b0;
        bus.rdata_o      = '0;
        case (state_q)
            IDLE: begin
                bus.stall_o      = bus.req_i && !bus.we_i;
                bus.misaligned_o = bus.req_i && mis;
            end
            LOAD_DONE: bus.rdata_o = ext;
            default: ;
        endcase
    end

endmodule
